fetch_unit: RTL

//   Instruction-fetch stage directly upstream of Control/ALU in the 8-bit single-cycle core.

---
 rtl/fetch_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the instruction ROM combinationally,
// resolves branches/stalls/halt and counts retired instructions.
module fetch_unit #(
    parameter int PW    = 8,
    parameter int IW    = 9,
    parameter int DEPTH = 256,
    // ROM image packed low-entry-first: entry i lives at bits [i*IW +: IW]
    parameter logic [DEPTH*IW-1:0] ROM_IMAGE = '0
) (
    input  logic          CLK,
    input  logic          start,
    input  logic          stall,
    input  logic          branch,
    input  logic          jump,
    input  logic [PW-1:0] target,
    input  logic          halt,
    output logic [IW-1:0] Instruction,
    output logic [PW-1:0] PC,
    output logic          valid,
    output logic          taken,
    output logic          halted,
    output logic [15:0]   inst_count
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] countNext;
    logic [IW-1:0] romWord;

    assign countNext = (inst_count == 16'hFFFF) ? inst_count : inst_count + 16'd1;

    always_ff @(posedge CLK) begin
        if (start) begin
            state      <= BOOT;
            PC         <= '0;
            valid      <= 1'b0;
            taken      <= 1'b0;
            halted     <= 1'b0;
            inst_count <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    valid <= 1'b1;
                end
                RUN: begin
                    // halt outranks stall, which outranks any branch request
                    if (halt) begin
                        state      <= HALTED;
                        valid      <= 1'b0;
                        halted     <= 1'b1;
                        taken      <= 1'b0;
                        inst_count <= countNext;
                    end else if (stall) begin
                        taken <= 1'b0;
                    end else begin
                        inst_count <= countNext;
                        if (branch && jump) begin
                            PC    <= target;
                            taken <= 1'b1;
                        end else begin
                            PC    <= PC + PW'(1);
                            taken <= 1'b0;
                        end
                    end
                end
                HALTED: begin
                end
                default: begin
                    state <= BOOT;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign romWord = ROM_IMAGE[PC*IW +: IW];

    // Addresses beyond a shallow ROM read as all-zero instead of aliasing
    generate
        if (DEPTH < 2**PW) begin : g_partial
            assign Instruction = (int'(PC) < DEPTH) ? romWord : '0;
        end else begin : g_full
            assign Instruction = romWord;
        end
    endgenerate

endmodule
